// File: rtl/alu_operand_loader.sv
// ALU front end: captures operands/opcode from the databus, issues a start pulse,
// waits out the fixed ALU latency and pulses grab for the result latch.
module alu_operand_loader #(
    parameter int unsigned ALU_LATENCY = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] bus_in,
    input  logic       load_a,
    input  logic       load_b,
    input  logic       load_op,
    input  logic       execute,
    output logic [7:0] operand_a,
    output logic [7:0] operand_b,
    output logic [3:0] opcode,
    output logic       alu_start,
    output logic       grab,
    output logic       busy,
    output logic       reject
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GRAB  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   counter_next;
    logic               load_en;
    logic               any_strobe;
    logic               reject_next;

    // State and latency counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // Next-state, counter and strobe-acceptance decode
    always_comb begin
        state_next   = state;
        counter_next = counter;
        load_en      = 1'b0;
        any_strobe   = load_a | load_b | load_op | execute;
        reject_next  = 1'b0;

        case (state)
            S_IDLE: begin
                load_en = 1'b1;
                if (execute) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                reject_next  = any_strobe;
                counter_next = CNT_W'(ALU_LATENCY - 1);
                state_next   = (ALU_LATENCY == 1) ? S_GRAB : S_WAIT;
            end
            S_WAIT: begin
                reject_next = any_strobe;
                if (counter == CNT_W'(1)) begin
                    state_next = S_GRAB;
                end else begin
                    counter_next = counter - CNT_W'(1);
                end
            end
            S_GRAB: begin
                reject_next = any_strobe;
                state_next  = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand/opcode registers: written only on strobes accepted in IDLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            operand_a <= '0;
            operand_b <= '0;
            opcode    <= '0;
        end else if (load_en) begin
            if (load_a) begin
                operand_a <= DATA_W'(bus_in);
            end
            if (load_b) begin
                operand_b <= DATA_W'(bus_in);
            end
            if (load_op) begin
                opcode <= OP_W'(bus_in[3:0]);
            end
        end
    end

    // Control outputs track the state register, so they are loaded from its next value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_start <= 1'b0;
            grab      <= 1'b0;
            busy      <= 1'b0;
            reject    <= 1'b0;
        end else begin
            alu_start <= (state_next == S_ISSUE);
            grab      <= (state_next == S_GRAB);
            busy      <= (state_next != S_IDLE);
            reject    <= reject_next;
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench: four loaders with different latencies share one stimulus
// stream and are compared against a cycle-phase reference model.
module tb_alu_operand_loader;

    localparam int N_DUT = 4;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 15;
            default: return 4;
        endcase
    endfunction

    logic       clock;
    logic       reset;
    logic [7:0] bus_in;
    logic       load_a;
    logic       load_b;
    logic       load_op;
    logic       execute;

    logic [7:0] oa  [N_DUT];
    logic [7:0] ob  [N_DUT];
    logic [3:0] oop [N_DUT];
    logic       st  [N_DUT];
    logic       gr  [N_DUT];
    logic       bz  [N_DUT];
    logic       rj  [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        alu_operand_loader #(.ALU_LATENCY(lat_of(g))) u_dut (
            .clock     (clock),
            .reset     (reset),
            .bus_in    (bus_in),
            .load_a    (load_a),
            .load_b    (load_b),
            .load_op   (load_op),
            .execute   (execute),
            .operand_a (oa[g]),
            .operand_b (ob[g]),
            .opcode    (oop[g]),
            .alu_start (st[g]),
            .grab      (gr[g]),
            .busy      (bz[g]),
            .reject    (rj[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp;
    int n_bad;

    // Reference model: phase = cycles since the accepted execute (0 = idle)
    int m_a     [N_DUT];
    int m_b     [N_DUT];
    int m_op    [N_DUT];
    int m_phase [N_DUT];
    int m_rej   [N_DUT];

    task automatic check(input string name, input int inst, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s dut%0d (lat %0d) t=%0t: got %0h, want %0h",
                     name, inst, lat_of(inst), $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_DUT; i++) begin
            m_a[i] = 0; m_b[i] = 0; m_op[i] = 0; m_phase[i] = 0; m_rej[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N_DUT; i++) begin
            if (m_phase[i] == 0) begin
                if (load_a)  m_a[i]  = int'(bus_in);
                if (load_b)  m_b[i]  = int'(bus_in);
                if (load_op) m_op[i] = int'(bus_in) % 16;
                m_rej[i] = 0;
                if (execute) m_phase[i] = 1;
            end else begin
                m_rej[i]   = (load_a | load_b | load_op | execute) ? 1 : 0;
                m_phase[i] = (m_phase[i] == lat_of(i) + 1) ? 0 : m_phase[i] + 1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N_DUT; i++) begin
            check("operand_a", i, int'(oa[i]),  m_a[i]);
            check("operand_b", i, int'(ob[i]),  m_b[i]);
            check("opcode",    i, int'(oop[i]), m_op[i]);
            check("alu_start", i, int'(st[i]),  (m_phase[i] == 1) ? 1 : 0);
            check("grab",      i, int'(gr[i]),  (m_phase[i] == lat_of(i) + 1) ? 1 : 0);
            check("busy",      i, int'(bz[i]),  (m_phase[i] != 0) ? 1 : 0);
            check("reject",    i, int'(rj[i]),  m_rej[i]);
        end
    endtask

    task automatic step(input logic la, input logic lb, input logic lo,
                        input logic ex, input logic [7:0] bus);
        @(negedge clock);
        load_a = la; load_b = lb; load_op = lo; execute = ex; bus_in = bus;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        load_a = 0; load_b = 0; load_op = 0; execute = 0; bus_in = 8'h00;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Execute now, then watch a fixed window and check pulse counts and grab timing
    task automatic run_op_timing(input logic [7:0] bus);
        int n_st [N_DUT];
        int n_gr [N_DUT];
        int t_gr [N_DUT];
        for (int i = 0; i < N_DUT; i++) begin
            n_st[i] = 0; n_gr[i] = 0; t_gr[i] = -1;
        end
        step(1, 0, 0, 1, bus);
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) step(0, 0, 0, 0, 8'h00);
            for (int i = 0; i < N_DUT; i++) begin
                if (st[i]) n_st[i]++;
                if (gr[i]) begin
                    n_gr[i]++;
                    if (t_gr[i] < 0) t_gr[i] = k;
                end
            end
        end
        for (int i = 0; i < N_DUT; i++) begin
            check("start_count", i, n_st[i], 1);
            check("grab_count",  i, n_gr[i], 1);
            check("grab_cycle",  i, t_gr[i], lat_of(i) + 1);
        end
    endtask

    typedef struct {
        logic       la, lb, lo, ex;
        logic [7:0] bus;
        logic [7:0] ea, eb;
        logic [3:0] eop;
        logic       es, eg, ebusy, erej;
    } vec_t;

    function automatic vec_t mk(input logic la, input logic lb, input logic lo, input logic ex,
                                input logic [7:0] bus, input logic [7:0] ea, input logic [7:0] eb,
                                input logic [3:0] eop, input logic es, input logic eg,
                                input logic ebusy, input logic erej);
        vec_t v;
        v.la = la; v.lb = lb; v.lo = lo; v.ex = ex; v.bus = bus;
        v.ea = ea; v.eb = eb; v.eop = eop;
        v.es = es; v.eg = eg; v.ebusy = ebusy; v.erej = erej;
        return v;
    endfunction

    vec_t tbl [20];

    initial begin
        int n_gr_after;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        load_a = 0; load_b = 0; load_op = 0; execute = 0; bus_in = 8'h00;
        model_reset();

        // Expected values for the latency-2 instance, one row per edge
        tbl[0]  = mk(1,0,0,0, 8'h3C, 8'h3C, 8'h00, 4'h0, 0,0,0,0);
        tbl[1]  = mk(0,1,0,0, 8'h05, 8'h3C, 8'h05, 4'h0, 0,0,0,0);
        tbl[2]  = mk(0,0,1,0, 8'h7A, 8'h3C, 8'h05, 4'hA, 0,0,0,0);
        tbl[3]  = mk(0,0,0,1, 8'h00, 8'h3C, 8'h05, 4'hA, 1,0,1,0);
        tbl[4]  = mk(0,0,0,0, 8'h00, 8'h3C, 8'h05, 4'hA, 0,0,1,0);
        tbl[5]  = mk(0,0,0,0, 8'h00, 8'h3C, 8'h05, 4'hA, 0,1,1,0);
        tbl[6]  = mk(0,0,0,0, 8'h00, 8'h3C, 8'h05, 4'hA, 0,0,0,0);
        tbl[7]  = mk(0,0,0,1, 8'h00, 8'h3C, 8'h05, 4'hA, 1,0,1,0);
        tbl[8]  = mk(1,0,0,0, 8'hFF, 8'h3C, 8'h05, 4'hA, 0,0,1,1);
        tbl[9]  = mk(0,0,0,1, 8'h00, 8'h3C, 8'h05, 4'hA, 0,1,1,1);
        tbl[10] = mk(0,0,0,0, 8'h00, 8'h3C, 8'h05, 4'hA, 0,0,0,0);
        tbl[11] = mk(1,0,0,1, 8'h11, 8'h11, 8'h05, 4'hA, 1,0,1,0);
        tbl[12] = mk(0,0,0,0, 8'h00, 8'h11, 8'h05, 4'hA, 0,0,1,0);
        tbl[13] = mk(0,0,0,0, 8'h00, 8'h11, 8'h05, 4'hA, 0,1,1,0);
        tbl[14] = mk(0,0,0,0, 8'h00, 8'h11, 8'h05, 4'hA, 0,0,0,0);
        tbl[15] = mk(1,1,0,1, 8'h99, 8'h99, 8'h99, 4'hA, 1,0,1,0);
        tbl[16] = mk(0,0,0,0, 8'h00, 8'h99, 8'h99, 4'hA, 0,0,1,0);
        tbl[17] = mk(0,0,0,0, 8'h00, 8'h99, 8'h99, 4'hA, 0,1,1,0);
        tbl[18] = mk(0,0,0,1, 8'h00, 8'h99, 8'h99, 4'hA, 0,0,0,1);
        tbl[19] = mk(0,0,0,0, 8'h00, 8'h99, 8'h99, 4'hA, 0,0,0,0);

        #2;
        check_all();
        do_reset();

        for (int r = 0; r < 20; r++) begin
            step(tbl[r].la, tbl[r].lb, tbl[r].lo, tbl[r].ex, tbl[r].bus);
            check($sformatf("tbl%0d.operand_a", r), 0, int'(oa[0]),  int'(tbl[r].ea));
            check($sformatf("tbl%0d.operand_b", r), 0, int'(ob[0]),  int'(tbl[r].eb));
            check($sformatf("tbl%0d.opcode", r),    0, int'(oop[0]), int'(tbl[r].eop));
            check($sformatf("tbl%0d.alu_start", r), 0, int'(st[0]),  int'(tbl[r].es));
            check($sformatf("tbl%0d.grab", r),      0, int'(gr[0]),  int'(tbl[r].eg));
            check($sformatf("tbl%0d.busy", r),      0, int'(bz[0]),  int'(tbl[r].ebusy));
            check($sformatf("tbl%0d.reject", r),    0, int'(rj[0]),  int'(tbl[r].erej));
        end

        // Latency sweep from a clean start: one start, one grab at cycle N+1+L
        do_reset();
        run_op_timing(8'h42);

        // Asynchronous reset in the middle of the latency-4 WAIT phase
        do_reset();
        step(1, 1, 0, 0, 8'h5A);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        check("pre_reset_busy", 3, int'(bz[3]), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_busy",      3, int'(bz[3]), 0);
        check("async_start",     3, int'(st[3]), 0);
        check("async_grab",      3, int'(gr[3]), 0);
        check("async_operand_a", 3, int'(oa[3]), 0);
        check("async_operand_b", 3, int'(ob[3]), 0);
        model_reset();
        check_all();
        @(negedge clock);
        reset = 1'b0;
        n_gr_after = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 0, 8'h00);
            if (gr[3]) n_gr_after++;
        end
        check("grab_after_abort", 3, n_gr_after, 0);
        run_op_timing(8'h22);

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            step(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Front end of the ALU datapath: captures operand A, operand B and a 4-bit opcode from the 8-bit databus under bus-control strobes, presents them to the ALU, issues a one-cycle start, counts the ALU's fixed latency, then pulses `grab` so the result latch captures the ALU output. It is the write side of the ALU path, and the result latch is the read side. While an operation is in flight, the operands are frozen, and any new bus strobes are rejected and flagged.

## Interface

Parameters:
- ALU_LATENCY, 2, cycles from the `alu_start` cycle to the cycle the ALU result/flags are valid; legal range 1..15.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- bus_in  in  8  databus value, sampled on load strobes.
- load_a  in  1  capture `bus_in` into operand A.
- load_b  in  1  capture `bus_in` into operand B.
- load_op  in  1  capture `bus_in[3:0]` into opcode.
- execute  in  1  start an operation with the current operands/opcode.
- operand_a  out  8  registered operand A to the ALU.
- operand_b  out  8  registered operand B to the ALU.
- opcode  out  4  registered opcode to the ALU.
- alu_start  out  1  one-cycle pulse, high during the ISSUE state.
- grab  out  1  one-cycle pulse to the result latch, high during the GRAB state.
- busy  out  1  high in ISSUE, WAIT and GRAB.
- reject  out  1  one-cycle pulse: the previous cycle sampled a strobe while busy.

## Operation

- Reset values: operand_a=0, operand_b=0, opcode=0, alu_start=0, grab=0, busy=0, reject=0, state=IDLE, counter=0.
- FSM states: IDLE, ISSUE, WAIT, GRAB. Outputs `alu_start`, `grab` and `busy` are decoded from the registered state only.
- IDLE:
  - Load strobes are accepted at the edge.
  - Simultaneous `load_a` and `load_b` both capture the same `bus_in`.
  - `execute` → ISSUE.
  - A load and `execute` at the same edge: the new operand value is used by the operation.
- ISSUE: counter ← ALU_LATENCY−1. Next state is GRAB if ALU_LATENCY==1, else WAIT.
- WAIT: if counter==1 → GRAB, else counter decrements and state stays WAIT.
- GRAB → IDLE unconditionally.
- While busy, operand/opcode registers are not written. `load_a`, `load_b`, `load_op` or `execute` sampled while busy are dropped and set `reject` for the next cycle.
- Strobes sampled in the GRAB cycle are also rejected; a new `execute` is accepted from the IDLE cycle onward.
- Reset mid-operation: the operation is aborted immediately, with no `grab` pulse; operands clear to 0.
- ALU_LATENCY outside 1..15 is illegal; behaviour is undefined and no check is required.

## Timing

- `execute` sampled at edge N (state IDLE):
  - `alu_start` and `busy` are high in cycle N+1.
  - `grab` is high in cycle N+1+ALU_LATENCY.
  - `busy` stays high through the GRAB cycle.
  - IDLE resumes in cycle N+2+ALU_LATENCY.
- Back-to-back throughput: one operation per ALU_LATENCY+2 cycles.
- Operand and opcode outputs change only at accepted-load edges, so they are stable from ISSUE through GRAB.
- `reject` is high exactly one cycle, the cycle after the offending edge. Multiple strobes at one edge produce a single pulse.
- All outputs go to their reset values asynchronously while `reset` is high, independent of `clock`.

## Test plan

- Reset, then load_a with bus 0x3C, load_b with 0x05, load_op with 0x7A, and execute at edge N (ALU_LATENCY=2) → operand_a=0x3C, operand_b=0x05, opcode=0xA; alu_start only in cycle N+1; grab only in cycle N+3; busy in N+1..N+3.
- ALU_LATENCY=1 and ALU_LATENCY=15: execute at edge N → grab in cycle N+2 and N+16 respectively; exactly one alu_start and one grab per operation.
- load_a with 0xFF at the ISSUE edge and execute in the WAIT cycle → operand_a unchanged, no second alu_start, reject high for one cycle after each offending edge.
- load_a with bus 0x11 at the same edge as execute in IDLE → operand_a=0x11 during ISSUE; simultaneous load_a and load_b with 0x99 → both operands 0x99.
- Assert reset asynchronously mid-WAIT (ALU_LATENCY=4) → busy, alu_start and grab go low and operands go 0 without a clock edge; no grab pulse follows; the next execute behaves as from cold.
- Execute accepted in the IDLE cycle immediately after GRAB → the second operation starts with no gap beyond ALU_LATENCY+2 cycles and no reject.
